// File: rtl/conv_mac_engine.sv
// conv_mac_engine
//
// Streaming multiply-accumulate engine for the convolution datapath.
// Each accepted beat multiplies an unsigned pixel by a signed kernel
// coefficient. TAPS consecutive products are summed into one signed window
// result, which is then offered on a valid/ready output port.
//
// Pipeline: P (product register) -> A (accumulator) -> R (result register).
// A full output register that is not being consumed stalls the whole pipe.
//
// Optional feature macro: CONV_CLAMP_EN
//   When defined, the value written to sum is clamped to [0, 2^PIX_W-1].
//   The accumulator is never clamped.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clr        synchronous abort of the partial window
//   a          unsigned pixel (PIX_W)
//   b          signed coefficient (COEF_W)
//   a_valid    input beat valid
//   a_ready    input beat accepted when a_valid && a_ready
//   sum        signed window result (ACC_W)
//   sum_valid  result valid
//   sum_ready  result consumed when sum_valid && sum_ready
//   tap_idx    index of the next tap to be accepted
module conv_mac_engine #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 4,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 17,
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [PIX_W-1:0]        a,
  input  logic [COEF_W-1:0]       b,
  input  logic                    a_valid,
  output logic                    a_ready,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [CNT_W-1:0]        tap_idx
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  logic [CNT_W-1:0]         tap_cnt;
  logic signed [PROD_W-1:0] a_s;
  logic signed [PROD_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  p_reg;
  logic                     p_valid;
  logic                     p_last;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  sum_next;
  logic                     stall;
  logic                     accept;
  logic                     complete;

  assign stall   = sum_valid && !sum_ready;
  assign a_ready = !stall && !clr;
  assign accept  = a_valid && a_ready;
  assign tap_idx = tap_cnt;

  // The pixel gets a zero sign bit so the product is a plain signed multiply.
  assign a_s  = {{(COEF_W + 1){1'b0}}, a};
  assign b_s  = {{(PIX_W + 1){b[COEF_W-1]}}, b};
  assign prod = a_s * b_s;

  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end else begin : g_trunc
      assign prod_ext = prod[ACC_W-1:0];
    end
  endgenerate

  assign acc_next = acc + p_reg;

  // A window completes when a valid last product sits in P and the pipe moves.
  assign complete = p_valid && p_last && !stall && !clr;

`ifdef CONV_CLAMP_EN
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);

  always_comb begin
    sum_next = acc_next;
    if (acc_next[ACC_W-1]) begin
      sum_next = '0;
    end else if (acc_next > PIX_MAX) begin
      sum_next = PIX_MAX;
    end
  end
`else
  assign sum_next = acc_next;
`endif

  // Tap counter: wraps after the last tap so back-to-back windows line up.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tap_cnt <= '0;
    end else if (accept) begin
      tap_cnt <= (tap_cnt == LAST_CNT) ? '0 : tap_cnt + CNT_W'(1);
    end
  end

  // P stage: product plus flags; a bubble is loaded when no beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (clr) begin
      p_valid <= 1'b0;
    end else if (!stall) begin
      p_reg   <= prod_ext;
      p_valid <= accept;
      p_last  <= (tap_cnt == LAST_CNT);
    end
  end

  // A stage: reload to zero on the last product so the next window starts clean.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (!stall && p_valid) begin
      acc <= p_last ? '0 : acc_next;
    end
  end

  // R stage: a new result overrides the handshake clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else if (complete) begin
      sum       <= sum_next;
      sum_valid <= 1'b1;
    end else if (sum_valid && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule
